// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bcd_pkg;

    localparam int MAX_BCD_VALUE = 9999;
    localparam int NUM_DIGITS    = 4;
    localparam int BCD_W         = 4;
    localparam int BCD_REG_W     = NUM_DIGITS * BCD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    // Conditional +3 correction
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble converter: one shift per clock, four BCD digits,
// results registered and held between conversions, saturating at 9999.
module bin_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [BIN_WIDTH-1:0] BIN,
    input  logic                 START,
    output logic [BCD_W-1:0]     D0,
    output logic [BCD_W-1:0]     D1,
    output logic [BCD_W-1:0]     D2,
    output logic [BCD_W-1:0]     D3,
    output logic                 OVF,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int SR_W  = BCD_REG_W + BIN_WIDTH;
    localparam int CNT_W = 5;

    // Clamp value in operand width; only reachable when BIN_WIDTH >= 14
    localparam logic [BIN_WIDTH-1:0] CLAMP_VAL = BIN_WIDTH'(MAX_BCD_VALUE);
    localparam logic [16:0]          MAX_EXT   = 17'(MAX_BCD_VALUE);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SR_W-1:0]        r_sr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf_pend;
    logic [BCD_REG_W-1:0]   r_bcd;
    logic                   r_ovf;
    logic                   r_done;

    logic [16:0]            w_bin_ext;
    logic                   w_ovf;
    logic [BIN_WIDTH-1:0]   w_operand;
    logic [BCD_REG_W-1:0]   w_adj_bcd;
    logic [SR_W-1:0]        w_adj_sr;
    logic [SR_W-1:0]        w_sr_next;
    logic                   w_busy;

    // Input clamp: compare in a width wide enough for any legal BIN_WIDTH
    always_comb begin
        w_bin_ext = 17'(BIN);
        w_ovf     = (w_bin_ext > MAX_EXT);
        w_operand = w_ovf ? CLAMP_VAL : BIN;
    end

    // One correction cell per BCD digit of the shift register
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_sr[BIN_WIDTH + g*BCD_W +: BCD_W]),
            .o_digit (w_adj_bcd[g*BCD_W +: BCD_W])
        );
    end

    // Adjust-then-shift step of the whole {BCD, binary} register
    always_comb begin
        w_adj_sr  = {w_adj_bcd, r_sr[BIN_WIDTH-1:0]};
        w_sr_next = {w_adj_sr[SR_W-2:0], 1'b0};
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (START) w_next_state = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(1)) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    // Datapath: load on accepted START, shift while converting, publish on DONE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_sr       <= {{BCD_REG_W{1'b0}}, w_operand};
                        r_cnt      <= CNT_W'(BIN_WIDTH);
                        r_ovf_pend <= w_ovf;
                    end
                end
                ST_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    r_bcd  <= r_sr[SR_W-1 -: BCD_REG_W];
                    r_ovf  <= r_ovf_pend;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign D0   = r_bcd[0*BCD_W +: BCD_W];
    assign D1   = r_bcd[1*BCD_W +: BCD_W];
    assign D2   = r_bcd[2*BCD_W +: BCD_W];
    assign D3   = r_bcd[3*BCD_W +: BCD_W];
    assign OVF  = r_ovf;
    assign BUSY = w_busy;
    assign DONE = r_done;

endmodule : bin_to_bcd_converter

// File: tb/tb_bin_to_bcd_converter.sv
// Scoreboard bench for bin_to_bcd_converter (BIN_WIDTH = 14).
module tb_bin_to_bcd_converter;

    localparam int W = 14;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] BIN   = '0;
    logic [3:0]   D0, D1, D2, D3;
    logic         OVF, BUSY, DONE;
    logic [16:0]  obs;

    int passed = 0;
    int total  = 0;
    logic [16:0] sb[$];

    bin_to_bcd_converter #(.BIN_WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BIN   (BIN),
        .START (START),
        .D0    (D0),
        .D1    (D1),
        .D2    (D2),
        .D3    (D3),
        .OVF   (OVF),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    assign obs = {D3, D2, D1, D0, OVF};

    // Reference: decimal digits of the clamped value plus overflow flag
    function automatic logic [16:0] model(input int unsigned v);
        int unsigned c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10), (v > 9999)};
    endfunction

    // Pulse START for one cycle, push the expectation, then watch 20 cycles
    task automatic convert(input int unsigned v, output int lat, output int busy_n, output int done_n);
        @(negedge CLK);
        BIN   = W'(v);
        START = 1'b1;
        sb.push_back(model(v));
        @(negedge CLK);
        START  = 1'b0;
        BIN    = W'($urandom);
        lat    = -1;
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                if (lat < 0) lat = k;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        logic [16:0] exp;
        RST_N = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            BIN   = W'($urandom);
            START = 1'($urandom);
            total++;
            if ({obs, BUSY, DONE} !== 19'd0) $display("FAIL reset_hold got=%h want=0", {obs, BUSY, DONE});
            else passed++;
        end
        START = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (8) @(negedge CLK);
        exp = '0;
        total++;
        if ({obs, BUSY, DONE} !== {exp, 2'b00}) $display("FAIL reset_idle got=%h want=0", {obs, BUSY, DONE});
        else passed++;
    endtask

    task automatic test_basic();
        int lat, bn, dn;
        logic [16:0] exp;
        convert(1234, lat, bn, dn);
        exp = sb.pop_front();
        total++;
        if (lat !== 15) $display("FAIL basic_latency got=%0d want=15", lat); else passed++;
        total++;
        if (bn !== 15) $display("FAIL basic_busy_cycles got=%0d want=15", bn); else passed++;
        total++;
        if (dn !== 1) $display("FAIL basic_done_count got=%0d want=1", dn); else passed++;
        total++;
        if (obs !== exp) $display("FAIL basic_result got=%h want=%h", obs, exp); else passed++;
        repeat (10) @(negedge CLK);
        total++;
        if (obs !== exp) $display("FAIL basic_hold got=%h want=%h", obs, exp); else passed++;
    endtask

    task automatic test_boundaries();
        int unsigned vals[3] = '{0, 9999, 10};
        int lat, bn, dn;
        logic [16:0] exp;
        foreach (vals[i]) begin
            convert(vals[i], lat, bn, dn);
            exp = sb.pop_front();
            total++;
            if (dn !== 1 || obs !== exp)
                $display("FAIL boundary_%0d got=%h done=%0d want=%h done=1", vals[i], obs, dn, exp);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        int unsigned vals[2] = '{12000, 42};
        int lat, bn, dn;
        logic [16:0] exp;
        foreach (vals[i]) begin
            convert(vals[i], lat, bn, dn);
            exp = sb.pop_front();
            total++;
            if (dn !== 1 || obs !== exp)
                $display("FAIL saturation_%0d got=%h done=%0d want=%h done=1", vals[i], obs, dn, exp);
            else passed++;
        end
    endtask

    task automatic test_ignore_busy();
        int dn;
        logic [16:0] exp;
        @(negedge CLK);
        BIN   = W'(5678);
        START = 1'b1;
        sb.push_back(model(5678));
        @(negedge CLK);
        START = 1'b0;
        dn    = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) begin
                BIN   = W'(42);
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
            if (DONE) dn++;
            @(negedge CLK);
        end
        exp = sb.pop_front();
        total++;
        if (dn !== 1) $display("FAIL busy_done_count got=%0d want=1", dn); else passed++;
        total++;
        if (obs !== exp) $display("FAIL busy_result got=%h want=%h", obs, exp); else passed++;
    endtask

    task automatic test_back_to_back();
        int t_prev, n, k;
        logic [16:0] exp;
        @(negedge CLK);
        BIN   = W'(2468);
        START = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(model(2468));
        t_prev = -1;
        n      = 0;
        k      = 0;
        while (n < 3 && k < 100) begin
            @(negedge CLK);
            k++;
            if (DONE) begin
                exp = sb.pop_front();
                total++;
                if (obs !== exp) $display("FAIL b2b_result_%0d got=%h want=%h", n, obs, exp); else passed++;
                if (t_prev >= 0) begin
                    total++;
                    if (k - t_prev !== 16) $display("FAIL b2b_period_%0d got=%0d want=16", n, k - t_prev);
                    else passed++;
                end
                t_prev = k;
                n++;
            end
        end
        START = 1'b0;
        total++;
        if (n !== 3) $display("FAIL b2b_timeout got=%0d dones want=3", n); else passed++;
        sb.delete();
        repeat (20) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int dn, lat, bn;
        logic [16:0] exp;
        @(negedge CLK);
        BIN   = W'(4321);
        START = 1'b1;
        sb.push_back(model(4321));
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        void'(sb.pop_front());
        total++;
        if ({obs, BUSY, DONE} !== 19'd0) $display("FAIL midreset_clear got=%h want=0", {obs, BUSY, DONE});
        else passed++;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        dn    = 0;
        for (int k = 0; k < 20; k++) begin
            if (DONE) dn++;
            @(negedge CLK);
        end
        total++;
        if (dn !== 0) $display("FAIL midreset_no_done got=%0d want=0", dn); else passed++;
        convert(4321, lat, bn, dn);
        exp = sb.pop_front();
        total++;
        if (dn !== 1 || obs !== exp) $display("FAIL midreset_fresh got=%h done=%0d want=%h done=1", obs, dn, exp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_saturation();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_bin_to_bcd_converter

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Iterative double-dabble converter from an unsigned binary count to four BCD digits.
- Sits directly upstream of the 4-digit 7-segment multiplexer; its D0..D3 outputs drive that block's digit inputs (units, tens, hundreds, thousands).
- Outputs are registered and held between conversions, so the display never shows intermediate shift values.
- Values above 9999 saturate to 9999 and raise an overflow flag.

Parameters:
- BIN_WIDTH, 14, width of binary input; legal range 4..16.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous reset, active-low.
- BIN  input  BIN_WIDTH  unsigned value to convert; sampled only on an accepted START.
- START  input  1  conversion request; level-sampled in IDLE only.
- D0  output  4  units digit (BCD), registered.
- D1  output  4  tens digit, registered.
- D2  output  4  hundreds digit, registered.
- D3  output  4  thousands digit, registered.
- OVF  output  1  last accepted BIN exceeded 9999, registered.
- BUSY  output  1  high while state is not IDLE.
- DONE  output  1  one-cycle pulse when D0..D3/OVF update.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST_N is asynchronous and active-low.
- Reset:
  - While RST_N is low: D0..D3 = 0, OVF = 0, DONE = 0, state = IDLE (BUSY = 0).
  - Internal shift register and counter are cleared.
  - Reset takes effect immediately and aborts any conversion in progress; no DONE is produced for the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - START = 1 at edge e0: operand = min(BIN, 9999); ovf_pend = (BIN > 9999).
  - Shift register = {16'b0, operand}; cnt = BIN_WIDTH; go to SHIFT.
  - START = 0: stay in IDLE.
- SHIFT (edges e1..e(BIN_WIDTH)), each edge:
  - Each 4-bit BCD nibble >= 5 gets +3 (combinational adjust).
  - Then the whole {BCD, binary} register shifts left by 1.
  - cnt decrements; the edge where cnt reaches 0 moves to DONE.
- DONE (edge e(BIN_WIDTH+1)):
  - Copy the BCD nibbles to D0..D3 and ovf_pend to OVF.
  - DONE register = 1; return to IDLE.
  - DONE clears on the next edge (exactly one cycle high).
- Latency: DONE is high in the cycle following edge e(BIN_WIDTH+1), i.e. BIN_WIDTH+1 edges after the edge that accepted START. BUSY is high for BIN_WIDTH+1 cycles.
- Throughput: START held continuously gives one conversion per BIN_WIDTH+2 cycles; the next START is sampled on the edge after the DONE state.
- START while BUSY is ignored (not queued). BIN changes after acceptance have no effect.
- D0..D3 and OVF change only on the DONE edge or on reset; they hold otherwise.
- Arithmetic:
  - BCD register is 16 bits; shift register is 16 + BIN_WIDTH bits.
  - A nibble never exceeds 9 after a completed conversion, because input is clamped to 9999.
- BIN_WIDTH < 14: the clamp never triggers and OVF stays 0.

Decomposition:
- Shared package/include bcd_pkg:
  - MAX_BCD_VALUE = 9999, NUM_DIGITS = 4, BCD_W = 4.
  - State encodings ST_IDLE / ST_SHIFT / ST_DONE.
- Sub-module bcd_digit_adjust: 4-bit in/out, adds 3 when input >= 5.
  - Purely combinational; instantiated NUM_DIGITS times inside the converter.

Test Plan:
- Reset: RST_N low with random BIN/START → D0..D3 = 0, OVF = 0, BUSY = 0, DONE = 0; after release, nothing changes until START.
- BIN = 1234, START pulsed 1 cycle →
  - BUSY high 15 cycles; DONE high exactly 1 cycle, 15 edges after acceptance.
  - D3..D0 = 1,2,3,4; OVF = 0; values hold afterwards.
- Boundaries:
  - BIN = 0 → 0,0,0,0.
  - BIN = 9999 → 9,9,9,9, OVF = 0.
  - BIN = 10 → 0,0,1,0.
- Saturation: BIN = 12000 → D3..D0 = 9,9,9,9, OVF = 1. A following BIN = 42 → 0,0,4,2, OVF = 0.
- Ignore while busy: BIN = 5678 accepted, then BIN = 42 with START re-pulsed at cycle 5 → single DONE, result 5,6,7,8. START held high continuously → DONE every 16 cycles.
- Reset mid-conversion: RST_N low at cycle 7 after BIN = 4321 accepted → outputs clear immediately, no DONE. Fresh START with BIN = 4321 → 4,3,2,1.
